dsp_pipe_reg: RTL and testbench

Parametrised multi-stage input pipeline for the DSP48A1 datapath, replacing single-register bypass stages on the A/B/C/D/M/P paths. It provides a register chain of up to 8 stages with a runtime-selectable output tap, a clock-enable stall, a valid bit travelling with each sample, a synchronous flush and an in-flight sample count. The surrounding DSP slice uses it wherever a path needs 0..DEPTH cycles of configurable latency.

---
 rtl/dsp_pipe_pkg.sv | 29 ++
 rtl/dsp_pipe_stage.sv | 44 ++++
 rtl/dsp_pipe_reg.sv | 89 ++++++++
 tb/tb_dsp_pipe_reg.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dsp_pipe_pkg.sv
// Shared constants and elaboration helpers for the DSP48A1 configurable
// latency pipeline (dsp_pipe_stage / dsp_pipe_reg).
package dsp_pipe_pkg;

    // Largest supported register chain and data path.
    localparam int MAX_DEPTH = 8;
    localparam int MAX_WIDTH = 48;

    // Ceiling log2, usable in parameter expressions.
    // clog2(1) = 0, clog2(2) = 1, clog2(5) = 3, clog2(9) = 4.
    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v      = value - 1;
        while (v > 0) begin
            result = result + 1;
            v      = v >> 1;
        end
        return result;
    endfunction

    // True when the requested geometry is inside the supported range.
    function automatic bit params_ok(input int depth, input int width);
        return (depth >= 1) && (depth <= MAX_DEPTH) &&
               (width >= 1) && (width <= MAX_WIDTH);
    endfunction

endpackage

// File: rtl/dsp_pipe_stage.sv
// One pipeline stage: a WIDTH-bit data register plus its valid bit.
// ce gates both; flush clears only the valid bit, the data is left alone.
module dsp_pipe_stage
    import dsp_pipe_pkg::*;
#(
    parameter int WIDTH = 18
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ce,
    input  logic             flush,
    input  logic [WIDTH-1:0] d,
    input  logic             d_vld,
    output logic [WIDTH-1:0] q,
    output logic             q_vld
);

    logic [WIDTH-1:0] r_data;
    logic             r_vld;

    // Data register: loads on enabled cycles, never touched by flush.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_data <= '0;
        end else if (ce) begin
            r_data <= d;
        end
    end

    // Valid bit: flush overrides ce so a sample presented during flush is dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vld <= 1'b0;
        end else if (flush) begin
            r_vld <= 1'b0;
        end else if (ce) begin
            r_vld <= d_vld;
        end
    end

    assign q     = r_data;
    assign q_vld = r_vld;

endmodule

// File: rtl/dsp_pipe_reg.sv
// Configurable-latency input pipeline for the DSP48A1 A/B/C/D/M/P paths.
// DEPTH register stages in a chain, a runtime tap select (0 = bypass,
// values above DEPTH clamp to DEPTH) and a count of valid samples held.
//
// Handshake: din_vld qualifies din on every cycle with ce = 1; there is no
// backpressure, one sample is accepted per enabled cycle, and dout_vld
// qualifies dout on the same cycle it is presented.
module dsp_pipe_reg
    import dsp_pipe_pkg::*;
#(
    parameter int WIDTH = 18,
    parameter int DEPTH = 4,
    parameter int TAPW  = clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ce,
    input  logic             flush,
    input  logic [TAPW-1:0]  tap,
    input  logic [WIDTH-1:0] din,
    input  logic             din_vld,
    output logic [WIDTH-1:0] dout,
    output logic             dout_vld,
    output logic [TAPW-1:0]  inflight
);

    localparam logic [TAPW-1:0] MAX_TAP = TAPW'(DEPTH);

    // Reject unsupported geometries at elaboration time.
    if (!params_ok(DEPTH, WIDTH)) begin : g_param_check
        $error("dsp_pipe_reg: DEPTH must be 1..%0d and WIDTH 1..%0d",
               MAX_DEPTH, MAX_WIDTH);
    end

    // Index 0 is the live input, index k is the output of stage k.
    logic [WIDTH-1:0] w_data [DEPTH+1];
    logic             w_vld  [DEPTH+1];
    logic [TAPW-1:0]  w_tap_sel;
    logic [TAPW-1:0]  w_count;

    assign w_data[0] = din;
    assign w_vld[0]  = din_vld;

    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        dsp_pipe_stage #(
            .WIDTH (WIDTH)
        ) u_stage (
            .clk   (clk),
            .rst   (rst),
            .ce    (ce),
            .flush (flush),
            .d     (w_data[i]),
            .d_vld (w_vld[i]),
            .q     (w_data[i+1]),
            .q_vld (w_vld[i+1])
        );
    end

    // Clamp out-of-range tap values to the last physical stage.
    always_comb begin
        w_tap_sel = tap;
        if (tap > MAX_TAP) begin
            w_tap_sel = MAX_TAP;
        end
    end

    // Output mux; changing tap takes effect immediately and is not retimed.
    always_comb begin
        dout     = '0;
        dout_vld = 1'b0;
        for (int i = 0; i <= DEPTH; i++) begin
            if (w_tap_sel == TAPW'(i)) begin
                dout     = w_data[i];
                dout_vld = w_vld[i];
            end
        end
    end

    // Popcount of the stage valid bits; the bypass input is not counted.
    always_comb begin
        w_count = '0;
        for (int i = 1; i <= DEPTH; i++) begin
            w_count = w_count + TAPW'(w_vld[i]);
        end
    end

    assign inflight = w_count;

endmodule

// File: tb/tb_dsp_pipe_reg.sv
// Directed bench for dsp_pipe_reg with WIDTH = 18, DEPTH = 4.
module tb_dsp_pipe_reg;

    localparam int WIDTH = 18;
    localparam int DEPTH = 4;
    localparam int TAPW  = 3;

    logic             clk;
    logic             rst;
    logic             ce;
    logic             flush;
    logic [TAPW-1:0]  tap;
    logic [WIDTH-1:0] din;
    logic             din_vld;
    logic [WIDTH-1:0] dout;
    logic             dout_vld;
    logic [TAPW-1:0]  inflight;

    int n_checks = 0;
    int n_fail   = 0;

    logic [WIDTH-1:0] exp_q [$];

    dsp_pipe_reg #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_dut (
        .clk      (clk),
        .rst      (rst),
        .ce       (ce),
        .flush    (flush),
        .tap      (tap),
        .din      (din),
        .din_vld  (din_vld),
        .dout     (dout),
        .dout_vld (dout_vld),
        .inflight (inflight)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- driver tasks ----------------
    // One active edge; inputs driven afterwards land 2 time units past it.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic drive(input logic [WIDTH-1:0] d, input logic v);
        din     = d;
        din_vld = v;
    endtask

    // ---------------- checker ----------------
    task automatic check_eq(input string tag, input logic [31:0] got,
                            input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst     = 1'b1;
        ce      = 1'b0;
        flush   = 1'b0;
        tap     = 3'd2;
        din     = '0;
        din_vld = 1'b0;
        #3;

        // Reset state
        check_eq("rst_dout",     32'(dout), 32'h0);
        check_eq("rst_dout_vld", 32'(dout_vld), 32'h0);
        check_eq("rst_inflight", 32'(inflight), 32'h0);
        tap = 3'd0;
        drive(18'h155, 1'b1);
        #1;
        check_eq("rst_bypass_dout", 32'(dout), 32'h155);
        check_eq("rst_bypass_vld",  32'(dout_vld), 32'h1);
        tap = 3'd2;
        drive('0, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        // Stream 1,2,3.. at tap 2: first valid output 2 enabled edges later
        ce = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            drive(WIDTH'(k), 1'b1);
            exp_q.push_back(WIDTH'(k));
            tick();
            if (k >= 2) begin
                check_eq("t2_vld",  32'(dout_vld), 32'h1);
                check_eq("t2_data", 32'(dout), 32'(exp_q.pop_front()));
            end else begin
                check_eq("t2_vld_early", 32'(dout_vld), 32'h0);
            end
            check_eq("t2_inflight", 32'(inflight), (k < 4) ? 32'(k) : 32'd4);
        end

        // Bypass at tap 0
        tap = 3'd0;
        drive(18'h2A5, 1'b1);
        #1;
        check_eq("byp_dout",     32'(dout), 32'h2A5);
        check_eq("byp_vld",      32'(dout_vld), 32'h1);
        check_eq("byp_inflight", 32'(inflight), 32'h4);
        din_vld = 1'b0;
        #1;
        check_eq("byp_vld_low", 32'(dout_vld), 32'h0);
        din_vld = 1'b1;
        tick();
        tap = 3'd1;
        #1;
        check_eq("byp_stage1",     32'(dout), 32'h2A5);
        check_eq("byp_stage1_vld", 32'(dout_vld), 32'h1);
        drive('0, 1'b0);
        for (int k = 3; k >= 0; k--) begin
            tick();
            check_eq("drain_inflight", 32'(inflight), 32'(k));
        end

        // Stall: 5,6 captured, ce low 2 cycles, then 7
        tap = 3'd3;
        drive(18'd5, 1'b1);
        tick();
        check_eq("stall_a_vld", 32'(dout_vld), 32'h0);
        drive(18'd6, 1'b1);
        tick();
        check_eq("stall_b_vld", 32'(dout_vld), 32'h0);
        check_eq("stall_b_infl", 32'(inflight), 32'h2);
        ce = 1'b0;
        drive(18'd99, 1'b1);
        for (int k = 0; k < 2; k++) begin
            tick();
            check_eq("stall_hold_vld",  32'(dout_vld), 32'h0);
            check_eq("stall_hold_infl", 32'(inflight), 32'h2);
        end
        ce = 1'b1;
        drive(18'd7, 1'b1);
        tick();
        check_eq("stall_e_data", 32'(dout), 32'd5);
        check_eq("stall_e_vld",  32'(dout_vld), 32'h1);
        check_eq("stall_e_infl", 32'(inflight), 32'h3);
        drive('0, 1'b0);
        tick();
        check_eq("stall_f_data", 32'(dout), 32'd6);
        check_eq("stall_f_vld",  32'(dout_vld), 32'h1);
        check_eq("stall_f_infl", 32'(inflight), 32'h3);
        tick();
        check_eq("stall_g_data", 32'(dout), 32'd7);
        check_eq("stall_g_vld",  32'(dout_vld), 32'h1);
        check_eq("stall_g_infl", 32'(inflight), 32'h2);
        tick();
        check_eq("stall_h_vld",  32'(dout_vld), 32'h0);
        check_eq("stall_h_infl", 32'(inflight), 32'h1);
        tick();
        check_eq("stall_i_infl", 32'(inflight), 32'h0);

        // Fill then flush with a sample presented
        tap = 3'd4;
        for (int k = 0; k < 4; k++) begin
            drive(WIDTH'(32'h10 + k), 1'b1);
            tick();
        end
        check_eq("fill_infl", 32'(inflight), 32'h4);
        check_eq("fill_data", 32'(dout), 32'h10);
        flush = 1'b1;
        drive(18'h3F, 1'b1);
        tick();
        flush = 1'b0;
        drive('0, 1'b0);
        check_eq("flush_infl", 32'(inflight), 32'h0);
        for (int t = 1; t <= 4; t++) begin
            tap = TAPW'(t);
            #1;
            check_eq("flush_vld", 32'(dout_vld), 32'h0);
        end
        tap = 3'd4;
        for (int k = 0; k < 4; k++) begin
            tick();
            check_eq("flush_after_infl", 32'(inflight), 32'h0);
            check_eq("flush_after_vld",  32'(dout_vld), 32'h0);
        end

        // Tap 7 clamps to tap 4
        tap = 3'd7;
        for (int k = 1; k <= 7; k++) begin
            drive(WIDTH'(32'h20 + k), (k <= 3));
            tick();
            check_eq("clamp7_vld", 32'(dout_vld), (k >= 4 && k <= 6) ? 32'h1 : 32'h0);
            if (k >= 4 && k <= 6) begin
                check_eq("clamp7_data", 32'(dout), 32'h20 + 32'(k - 3));
            end
            tap = 3'd4;
            #1;
            check_eq("clamp4_vld", 32'(dout_vld), (k >= 4 && k <= 6) ? 32'h1 : 32'h0);
            if (k >= 4 && k <= 6) begin
                check_eq("clamp4_data", 32'(dout), 32'h20 + 32'(k - 3));
            end
            tap = 3'd7;
        end
        check_eq("clamp_infl", 32'(inflight), 32'h0);

        // Asynchronous reset mid-cycle with 3 samples in flight
        tap = 3'd3;
        for (int k = 1; k <= 3; k++) begin
            drive(WIDTH'(32'h30 + k), 1'b1);
            tick();
        end
        ce = 1'b0;
        drive('0, 1'b0);
        #1;
        check_eq("arst_pre_infl", 32'(inflight), 32'h3);
        check_eq("arst_pre_data", 32'(dout), 32'h31);
        check_eq("arst_pre_vld",  32'(dout_vld), 32'h1);
        rst = 1'b1;
        #1;
        check_eq("arst_data", 32'(dout), 32'h0);
        check_eq("arst_vld",  32'(dout_vld), 32'h0);
        check_eq("arst_infl", 32'(inflight), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        ce  = 1'b1;
        drive(18'h44, 1'b1);
        tick();
        drive('0, 1'b0);
        check_eq("post_rst_1_vld", 32'(dout_vld), 32'h0);
        tick();
        check_eq("post_rst_2_vld", 32'(dout_vld), 32'h0);
        tick();
        check_eq("post_rst_3_vld",  32'(dout_vld), 32'h1);
        check_eq("post_rst_3_data", 32'(dout), 32'h44);
        check_eq("post_rst_3_infl", 32'(inflight), 32'h1);

        // ---------------- report ----------------
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
